// File: rtl/alu_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU on (DATA_WIDTH+1)-bit
// pre-extended operands; one quotient bit per cycle, sign fix-up in a final cycle.
module alu_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH:0]   div_s1,
    input  logic [DATA_WIDTH:0]   div_s2,
    input  logic                  div_start,
    input  logic                  div_kill,
    output logic [DATA_WIDTH:0]   div_quotient,
    output logic [DATA_WIDTH:0]   div_remainder,
    output logic                  div_done,
    output logic                  div_stall
);
    localparam int W  = DATA_WIDTH + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    remo_q, remo_d;
    logic            done_q, done_d;

    logic [W-1:0]    abs1, abs2;
    logic [W:0]      shift_w, trial_w;

    always_comb begin
        abs1    = div_s1[W-1] ? (~div_s1 + W'(1)) : div_s1;
        abs2    = div_s2[W-1] ? (~div_s2 + W'(1)) : div_s2;
        // Partial remainder stays below the divisor, so one extra bit covers the shift.
        shift_w = {rem_q, dvd_q[W-1]};
        trial_w = shift_w - {1'b0, dvs_q};

        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    if (div_s2 == '0) begin
                        quot_d  = '1;
                        remo_d  = div_s1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = abs1;
                        dvs_d   = abs2;
                        negq_d  = div_s1[W-1] ^ div_s2[W-1];
                        negr_d  = div_s1[W-1];
                        rem_d   = '0;
                        cnt_d   = CW'(W);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial_w[W]) begin
                    rem_d = trial_w[W-1:0];
                    dvd_d = {dvd_q[W-2:0], 1'b1};
                end else begin
                    rem_d = shift_w[W-1:0];
                    dvd_d = {dvd_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX: begin
                quot_d  = negq_q ? (~dvd_q + W'(1)) : dvd_q;
                remo_d  = negr_q ? (~rem_q + W'(1)) : rem_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A flush drops the op without touching the visible results.
        if (div_kill) begin
            state_d = IDLE;
            done_d  = 1'b0;
            quot_d  = quot_q;
            remo_d  = remo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
        end
    end

    assign div_quotient  = quot_q;
    assign div_remainder = remo_q;
    assign div_done      = done_q;
    assign div_stall     = div_start & ~done_q & ~div_kill;
endmodule

// File: tb/tb_alu_div_unit.sv
// Directed bench for alu_div_unit: signed/unsigned, divide by zero, overflow,
// back-to-back, flush and mid-operation reset, with hand-computed results.
module tb_alu_div_unit;
    logic        clk;
    logic        rst;
    logic [32:0] div_s1;
    logic [32:0] div_s2;
    logic        div_start;
    logic        div_kill;
    logic [32:0] div_quotient;
    logic [32:0] div_remainder;
    logic        div_done;
    logic        div_stall;

    int checks   = 0;
    int failures = 0;

    alu_div_unit #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_s1       (div_s1),
        .div_s2       (div_s2),
        .div_start    (div_start),
        .div_kill     (div_kill),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done),
        .div_stall    (div_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called just after a clock edge (cycle 0). Leaves div_start high and returns
    // one cycle after div_done, i.e. in the next op's cycle 0.
    task automatic do_op(input string tag, input logic [32:0] s1, input logic [32:0] s2,
                         input logic [32:0] exp_q, input logic [32:0] exp_r, input int exp_lat);
        int cyc;
        int stall_cnt;
        div_s1    = s1;
        div_s2    = s2;
        div_start = 1'b1;
        cyc       = 0;
        stall_cnt = 0;
        #1;
        if (div_stall) stall_cnt++;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (div_done) break;
            if (div_stall) stall_cnt++;
        end
        chk({tag, "_latency"}, 33'(cyc), 33'(exp_lat));
        chk({tag, "_quot"}, div_quotient, exp_q);
        chk({tag, "_rem"}, div_remainder, exp_r);
        chk({tag, "_stall_done"}, {32'd0, div_stall}, 33'd0);
        chk({tag, "_stall_cycles"}, 33'(stall_cnt), 33'(exp_lat));
        @(posedge clk);
        #1;
        chk({tag, "_single_pulse"}, {32'd0, div_done}, 33'd0);
    endtask

    initial begin
        rst       = 1'b1;
        div_start = 1'b1;
        div_kill  = 1'b0;
        div_s1    = '0;
        div_s2    = '0;
        #2;
        chk("reset_stall", {32'd0, div_stall}, 33'd1);
        chk("reset_quot", div_quotient, 33'd0);
        chk("reset_rem", div_remainder, 33'd0);
        chk("reset_done", {32'd0, div_done}, 33'd0);
        div_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op("neg7_div2", 33'h1_FFFF_FFF9, 33'd2, 33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF, 35);
        div_start = 1'b0;
        @(posedge clk); #1;

        do_op("unsigned", 33'h0_FFFF_FFFF, 33'h0_0000_0010, 33'h0_0FFF_FFFF, 33'h0_0000_000F, 35);
        div_start = 1'b0;
        @(posedge clk); #1;

        do_op("div0", 33'h0_0000_1234, 33'd0, 33'h1_FFFF_FFFF, 33'h0_0000_1234, 1);
        div_start = 1'b0;
        @(posedge clk); #1;

        do_op("overflow", 33'h1_8000_0000, 33'h1_FFFF_FFFF, 33'h0_8000_0000, 33'd0, 35);
        div_start = 1'b0;
        @(posedge clk); #1;

        do_op("pos7_divneg2", 33'd7, 33'h1_FFFF_FFFE, 33'h1_FFFF_FFFD, 33'd1, 35);
        div_start = 1'b0;
        @(posedge clk); #1;

        do_op("b2b_first", 33'd100, 33'd7, 33'd14, 33'd2, 35);
        do_op("b2b_second", 33'd9, 33'd3, 33'd3, 33'd0, 35);
        div_start = 1'b0;
        @(posedge clk); #1;

        div_s1    = 33'd50;
        div_s2    = 33'd5;
        div_start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        div_kill = 1'b1;
        #1;
        chk("kill_stall", {32'd0, div_stall}, 33'd0);
        @(posedge clk);
        #1;
        div_kill  = 1'b0;
        div_start = 1'b0;
        chk("kill_no_done", {32'd0, div_done}, 33'd0);
        chk("kill_quot_held", div_quotient, 33'd3);
        chk("kill_rem_held", div_remainder, 33'd0);
        @(posedge clk);
        #1;
        do_op("after_kill", 33'd50, 33'd5, 33'd10, 33'd0, 35);
        div_start = 1'b0;
        @(posedge clk); #1;

        div_s1    = 33'd100;
        div_s2    = 33'd7;
        div_start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_quot", div_quotient, 33'd0);
        chk("rst_mid_rem", div_remainder, 33'd0);
        chk("rst_mid_done", {32'd0, div_done}, 33'd0);
        div_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op("after_rst", 33'd100, 33'd7, 33'd14, 33'd2, 35);
        div_start = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
